// File: rtl/sr_lab_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sr_lab_pkg
// Purpose  : Shared debounce-channel state encoding and default constants
//            for the sr_ff drive side.
// Revision : 1.0 - initial release
// ============================================================================
package sr_lab_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CHK_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_CHK_REL   = 2'd3;

    localparam int C_DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int C_CNT_W_DEFAULT           = 16;

endpackage : sr_lab_pkg
`default_nettype wire

// File: rtl/sr_button_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : sr_button_if
// Purpose   : Raw pushbutton inputs and clean S/R/level/conflict outputs of
//             the sr_ff button driver.
// Revision  : 1.0 - initial release
// ============================================================================
interface sr_button_if;

    logic btn_set_raw;
    logic btn_rst_raw;
    logic S;
    logic R;
    logic set_level;
    logic rst_level;
    logic conflict;

    // master: whoever owns the buttons and consumes the pulses
    modport master (
        output btn_set_raw,
        output btn_rst_raw,
        input  S,
        input  R,
        input  set_level,
        input  rst_level,
        input  conflict
    );

    modport slave (
        input  btn_set_raw,
        input  btn_rst_raw,
        output S,
        output R,
        output set_level,
        output rst_level,
        output conflict
    );

endinterface : sr_button_if
`default_nettype wire

// File: rtl/sr_button_driver_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : 2-flop synchronizer, counter debounce FSM and press-edge pulse
//            for one raw pushbutton.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import sr_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = C_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;
    logic             w_cnt_done;

    assign w_cnt_done = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2) begin
                        r_state <= ST_CHK_PRESS;
                        r_cnt   <= '0;
                    end
                end
                ST_CHK_PRESS: begin
                    if (!r_sync2) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= ST_CHK_REL;
                        r_cnt   <= '0;
                    end
                end
                ST_CHK_REL: begin
                    // release is silent: only the level drops
                    if (r_sync2) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign level       = r_level;
    assign press_pulse = r_pulse;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/sr_button_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_button_driver
// Purpose  : Debounces set/reset pushbuttons and emits mutually exclusive
//            single-cycle S/R pulses for sr_ff.
// Revision : 1.0 - initial release
// ============================================================================
module sr_button_driver
    import sr_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = C_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_button_if.slave  bus
);

    logic w_set_level;
    logic w_rst_level;
    logic w_set_pulse;
    logic w_rst_pulse;
    logic r_s;
    logic r_r;
    logic r_conflict;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (bus.btn_set_raw),
        .level       (w_set_level),
        .press_pulse (w_set_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_rst_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (bus.btn_rst_raw),
        .level       (w_rst_level),
        .press_pulse (w_rst_pulse)
    );

    // Coincident presses cancel so sr_ff never sees S=R=1; it simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= w_set_pulse & ~w_rst_pulse;
            r_r        <= w_rst_pulse & ~w_set_pulse;
            r_conflict <= w_set_pulse &  w_rst_pulse;
        end
    end

    assign bus.S         = r_s;
    assign bus.R         = r_r;
    assign bus.conflict  = r_conflict;
    assign bus.set_level = w_set_level;
    assign bus.rst_level = w_rst_level;

endmodule : sr_button_driver
`default_nettype wire

// File: tb/tb_sr_button_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_button_driver
// Purpose  : Directed self-checking bench for sr_button_driver (N=4, 10 ns clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_button_driver;

    localparam int          C_N    = 4;
    localparam int          C_LAT  = C_N + 4;            // S/R edge index, counting first sampling edge as 1
    localparam int          C_LVL  = C_N + 3;            // level change edge index
    localparam logic [63:0] C_ONES = {64{1'b1}};
    localparam logic [63:0] C_ZERO = 64'd0;
    localparam logic [63:0] C_BNC  = 64'hFFFF_FFFF_FFFF_FFF5; // 1,0,1,0 then steady 1
    localparam logic [63:0] C_GLT  = 64'h7;                   // 3 cycles high

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sr_button_if bus ();

    sr_button_driver #(
        .DEBOUNCE_CYCLES (C_N),
        .CNT_W           (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int n_s, n_r, n_c, f_s, f_r, f_c, n_sr;
    int f_ls1, f_ls0, f_lr0, max_ls, last_ls, last_lr;
    int errs;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit j-1 of each pattern is the raw level driven just before edge j.
    task automatic run(input int n, input logic [63:0] sp, input logic [63:0] rp);
        n_s = 0; n_r = 0; n_c = 0; f_s = 0; f_r = 0; f_c = 0; n_sr = 0;
        f_ls1 = 0; f_ls0 = 0; f_lr0 = 0; max_ls = 0;
        for (int j = 1; j <= n; j++) begin
            bus.btn_set_raw = sp[j-1];
            bus.btn_rst_raw = rp[j-1];
            @(posedge clk);
            #1;
            if (bus.S)        begin n_s++; if (f_s == 0) f_s = j; end
            if (bus.R)        begin n_r++; if (f_r == 0) f_r = j; end
            if (bus.conflict) begin n_c++; if (f_c == 0) f_c = j; end
            if (bus.S && bus.R) n_sr++;
            if (bus.set_level)  begin max_ls = 1; if (f_ls1 == 0) f_ls1 = j; end
            if (!bus.set_level && f_ls0 == 0) f_ls0 = j;
            if (!bus.rst_level && f_lr0 == 0) f_lr0 = j;
        end
        last_ls = int'(bus.set_level);
        last_lr = int'(bus.rst_level);
    endtask

    task automatic hold_reset(input int n);
        errs = 0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (bus.S || bus.R || bus.set_level || bus.rst_level || bus.conflict) errs++;
        end
    endtask

    initial begin
        bus.btn_set_raw = 1'b1;
        bus.btn_rst_raw = 1'b0;
        rst_n           = 1'b0;

        hold_reset(6);
        check("reset_outputs_zero", errs, 0);
        rst_n = 1'b1;
        run(20, C_ONES, C_ZERO);
        check("post_reset_S_count", n_s, 1);
        check("post_reset_S_edge", f_s, C_LAT);
        check("post_reset_set_level", last_ls, 1);
        run(20, C_ZERO, C_ZERO);
        check("release_no_S", n_s, 0);
        check("release_level_edge", f_ls0, C_LVL);
        check("release_level_final", last_ls, 0);

        run(20, C_ONES, C_ZERO);
        check("clean_S_count", n_s, 1);
        check("clean_S_edge", f_s, C_LAT);
        check("clean_no_R", n_r, 0);
        check("clean_level_rise_edge", f_ls1, C_LVL);
        check("clean_level_held", last_ls, 1);
        run(20, C_ZERO, C_ZERO);
        check("clean_release_level", last_ls, 0);

        run(24, C_ZERO, C_BNC);
        check("bounce_R_count", n_r, 1);
        check("bounce_R_edge", f_r, 4 + C_LAT);
        check("bounce_no_S", n_s, 0);
        check("bounce_rst_level", last_lr, 1);

        run(20, C_ONES, C_ONES);
        check("held_other_S_count", n_s, 1);
        check("held_other_S_edge", f_s, C_LAT);
        check("held_other_no_R", n_r, 0);
        check("held_other_no_conflict", n_c, 0);
        run(20, C_ZERO, C_ZERO);
        check("both_release_set_level", last_ls, 0);
        check("both_release_rst_level", last_lr, 0);
        check("both_release_no_pulse", n_s + n_r, 0);

        run(20, C_GLT, C_ZERO);
        check("glitch_no_S", n_s, 0);
        check("glitch_level_low", max_ls, 0);

        run(20, C_ONES, C_ONES);
        check("simul_conflict_count", n_c, 1);
        check("simul_conflict_edge", f_c, C_LAT);
        check("simul_no_S", n_s, 0);
        check("simul_no_R", n_r, 0);
        check("simul_no_overlap", n_sr, 0);
        run(20, C_ZERO, C_ZERO);
        check("simul_release_rst_level", f_lr0, C_LVL);

        run(2, C_ONES, C_ZERO);
        rst_n = 1'b0;
        hold_reset(2);
        check("mid_reset_outputs_zero", errs, 0);
        rst_n = 1'b1;
        run(20, C_ONES, C_ZERO);
        check("mid_reset_S_count", n_s, 1);
        check("mid_reset_S_edge", f_s, C_LAT);
        run(20, C_ZERO, C_ZERO);
        check("mid_reset_release", last_ls, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sr_button_driver
`default_nettype wire
